// File: rtl/key_expansion_iter.sv
// Iterative AES key schedule (NK = 4/6/8): one 32-bit round-key word per accepted beat.
// Optional macro KEYEXP_STORE_EN adds a readable copy of every emitted word (rd_idx/rd_word).
module key_expansion_iter #(
  parameter int NK   = 4,
  parameter int IDXW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [32*NK-1:0]  round_key,
  output logic [31:0]       word_out,
  output logic [IDXW-1:0]   word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
`ifdef KEYEXP_STORE_EN
  ,
  input  logic [IDXW-1:0]   rd_idx,
  output logic [31:0]       rd_word
`endif
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);
  localparam logic [IDXW-1:0] LAST     = IDXW'(TOTAL - 1);
  localparam logic [2:0]      POS_LAST = 3'(NK - 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("key_expansion_iter: NK must be 4, 6 or 8");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  typedef enum logic [1:0] {IDLE, KEY, EXPAND} state_t;

  state_t          state_q, state_d;
  logic [31:0]     win_q [NK];   // win_q[0] = w[i-NK] ... win_q[NK-1] = w[i-1]
  logic [7:0]      rcon_q;
  logic [IDXW-1:0] idx_q;
  logic [2:0]      pos_q;        // i mod NK, tracked incrementally
  logic            accept;

  logic [31:0] prev_w, sub_in, sub_out, temp, next_w, key_w;

  assign accept   = word_valid && word_ready;
  assign word_idx = idx_q;

  always_comb begin
    prev_w  = win_q[NK-1];
    sub_in  = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    if (pos_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && pos_q == 3'd4)
      temp = sub_out;
    else
      temp = prev_w;
    next_w = win_q[0] ^ temp;

    // during KEY the window still holds the raw key and pos_q == word index
    key_w = '0;
    for (int j = 0; j < NK; j++)
      if (pos_q == 3'(j)) key_w = win_q[j];
  end

  always_comb begin
    state_d    = state_q;
    word_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    word_out   = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = KEY;
      end
      KEY: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_out   = key_w;
        if (accept && pos_q == POS_LAST) state_d = EXPAND;
      end
      EXPAND: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_out   = next_w;
        if (accept && idx_q == LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (start) begin
          idx_q  <= '0;
          pos_q  <= '0;
          rcon_q <= 8'h01;
        end
      end else if (accept) begin
        idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        pos_q <= (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
        if (state_q == EXPAND && pos_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
    end
  end

  // window is pure data: loaded on start, shifted on each expanded word
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && start) begin
      for (int j = 0; j < NK; j++)
        win_q[j] <= round_key[32*(NK-j)-1 -: 32];
    end else if (!reset && state_q == EXPAND && accept) begin
      for (int j = 0; j < NK-1; j++)
        win_q[j] <= win_q[j+1];
      win_q[NK-1] <= next_w;
    end
  end

`ifdef KEYEXP_STORE_EN
  localparam logic [IDXW:0] TOTAL_W = (IDXW+1)'(TOTAL);

  logic [31:0] store_q [TOTAL];

  always_ff @(posedge clk) begin
    if (accept) store_q[word_idx] <= word_out;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_word <= '0;
    else if ({1'b0, rd_idx} >= TOTAL_W)
      rd_word <= '0;
    else
      rd_word <= store_q[rd_idx];
  end
`endif

endmodule

// File: tb/tb_key_expansion_iter.sv
// Bench for key_expansion_iter: three instances (NK=4/6/8), reference schedule model, scoreboard.
module tb_key_expansion_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_s [3];
  logic         ready_s [3];
  logic [255:0] key_s = '0;
  logic [31:0]  wo [3];
  logic [5:0]   wi [3];
  logic         wv [3];
  logic         bz [3];
  logic         dn [3];
`ifdef KEYEXP_STORE_EN
  logic [5:0]   rd_idx_s [3];
  logic [31:0]  rd_word_s [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_expansion_iter #(.NK(4 + 2*g), .IDXW(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s[g]),
      .round_key  (key_s[255 -: 32*(4+2*g)]),
      .word_out   (wo[g]),
      .word_idx   (wi[g]),
      .word_valid (wv[g]),
      .word_ready (ready_s[g]),
      .busy       (bz[g]),
      .done       (dn[g])
`ifdef KEYEXP_STORE_EN
      ,
      .rd_idx     (rd_idx_s[g]),
      .rd_word    (rd_word_s[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;
  exp_t sb [$];
  logic [31:0] mw [60];

  logic [255:0] keys [3] = '{
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
  };

  // published FIPS-197 values, independent of the reference model
  int          spot_s [7] = '{0, 0, 1, 1, 2, 2, 2};
  int          spot_i [7] = '{4, 43, 6, 51, 8, 12, 59};
  logic [31:0] spot_v [7] = '{32'ha0fafe17, 32'hb6630ca6, 32'hfe0c91f7, 32'h01002202,
                              32'h9ba35411, 32'ha8b09c1a, 32'h706c631e};

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_ref(logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_ref(logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  task automatic build_model(int nk, logic [255:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_ref(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // called at a negedge; returns at the negedge where w[0] should be visible
  task automatic start_run(int s, logic [255:0] key);
    int nk = 4 + 2*s;
    build_model(nk, key);
    sb.delete();
    for (int i = 0; i < 4*(nk+7); i++) sb.push_back('{idx: 6'(i), w: mw[i]});
    key_s = key;
    start_s[s] = 1'b1;
    @(negedge clk);
    start_s[s] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (wv[s] !== 1'b0 || bz[s] !== 1'b0 || dn[s] !== 1'b0 || wo[s] !== 32'h0 || wi[s] !== 6'h0) begin
        errors++;
        $display("FAIL reset_state nk%0d: valid %b busy %b done %b word %h idx %0d, expected all zero",
                 4+2*s, wv[s], bz[s], dn[s], wo[s], wi[s]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streams();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      int total = 4*(4+2*s+7);
      int cyc = 0, ndone = 0, dcyc = 0;
      ready_s[s] = 1'b1;
      start_run(s, keys[s]);
      while (sb.size() > 0 && cyc < 200) begin
        cyc++;
        #1;
        if (wv[s]) begin
          e = sb.pop_front();
          checks++;
          if (wi[s] !== e.idx || wo[s] !== e.w) begin
            errors++;
            $display("FAIL stream nk%0d: idx %0d word %h, expected idx %0d word %h",
                     4+2*s, wi[s], wo[s], e.idx, e.w);
          end
          for (int k = 0; k < 7; k++) begin
            if (spot_s[k] == s && spot_i[k] == int'(e.idx)) begin
              checks++;
              if (wo[s] !== spot_v[k]) begin
                errors++;
                $display("FAIL fips_word nk%0d w[%0d]: got %h, expected %h", 4+2*s, e.idx, wo[s], spot_v[k]);
              end
            end
          end
        end
        if (dn[s]) begin ndone++; dcyc = cyc; end
        @(negedge clk);
      end
      checks++;
      if (sb.size() != 0 || ndone != 1 || dcyc != total) begin
        errors++;
        $display("FAIL stream_done nk%0d: left %0d done %0d at cycle %0d, expected left 0 done 1 at cycle %0d",
                 4+2*s, sb.size(), ndone, dcyc, total);
      end
    end
  endtask

  task automatic test_stall();
    exp_t        e;
    int          cyc = 0, ndone = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pw = '0;
    logic [5:0]  pi = '0;
    start_run(0, keys[0]);
    while (sb.size() > 0 && cyc < 600) begin
      cyc++;
      ready_s[0] = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        checks++;
        if (wv[0] !== 1'b1 || wo[0] !== pw || wi[0] !== pi) begin
          errors++;
          $display("FAIL stall_hold: valid %b idx %0d word %h, expected valid 1 idx %0d word %h",
                   wv[0], wi[0], wo[0], pi, pw);
        end
      end
      prev_stall = wv[0] && !ready_s[0];
      pw = wo[0];
      pi = wi[0];
      if (wv[0] && ready_s[0]) begin
        e = sb.pop_front();
        checks++;
        if (wi[0] !== e.idx || wo[0] !== e.w) begin
          errors++;
          $display("FAIL stall_stream: idx %0d word %h, expected idx %0d word %h", wi[0], wo[0], e.idx, e.w);
        end
      end
      if (dn[0]) ndone++;
      @(negedge clk);
    end
    ready_s[0] = 1'b1;
    #1;
    checks++;
    if (sb.size() != 0 || ndone != 1 || bz[0] !== 1'b0 || wv[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: left %0d done %0d busy %b valid %b, expected 0 1 0 0",
               sb.size(), ndone, bz[0], wv[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc = 0;
    ready_s[0] = 1'b1;
    start_run(0, keys[0]);
    while (!(wv[0] === 1'b1 && wi[0] == 6'd20) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cyc >= 100 || wv[0] !== 1'b0 || bz[0] !== 1'b0 || dn[0] !== 1'b0 || wo[0] !== 32'h0 || wi[0] !== 6'h0) begin
      errors++;
      $display("FAIL reset_mid: cycles %0d valid %b busy %b done %b word %h idx %0d, expected all zero",
               cyc, wv[0], bz[0], dn[0], wo[0], wi[0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wv[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_words: valid %b, expected 0", wv[0]);
    end
    // start together with reset: reset wins
    @(negedge clk);
    start_s[0] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bz[0] !== 1'b0 || wv[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_with_reset: busy %b valid %b, expected 0 0", bz[0], wv[0]);
    end
    @(negedge clk);
    start_run(0, keys[0]);
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      cyc++;
      #1;
      if (wv[0]) begin
        e = sb.pop_front();
        checks++;
        if (wi[0] !== e.idx || wo[0] !== e.w || (e.idx == 6'd4 && wo[0] !== 32'ha0fafe17)) begin
          errors++;
          $display("FAIL restart_stream: idx %0d word %h, expected idx %0d word %h", wi[0], wo[0], e.idx, e.w);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL restart_timeout: %0d words missing, expected 0", sb.size());
    end
  endtask

  task automatic test_start_busy();
    exp_t e;
    int   cyc = 0, ndone = 0, dcyc = 0;
    ready_s[0] = 1'b1;
    start_run(0, keys[0]);
    while (sb.size() > 0 && cyc < 200) begin
      cyc++;
      if (cyc == 10) begin start_s[0] = 1'b1; key_s = {$urandom, $urandom, $urandom, $urandom, 128'h0}; end
      if (cyc == 11) start_s[0] = 1'b0;
      #1;
      if (wv[0]) begin
        e = sb.pop_front();
        checks++;
        if (wi[0] !== e.idx || wo[0] !== e.w) begin
          errors++;
          $display("FAIL busy_stream: idx %0d word %h, expected idx %0d word %h", wi[0], wo[0], e.idx, e.w);
        end
      end
      if (dn[0]) begin ndone++; dcyc = cyc; end
      @(negedge clk);
    end
    #1;
    checks++;
    if (sb.size() != 0 || ndone != 1 || dcyc != 44 || bz[0] !== 1'b0 || wv[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_restart: left %0d done %0d at %0d busy %b valid %b, expected 0 1 44 0 0",
               sb.size(), ndone, dcyc, bz[0], wv[0]);
    end
`ifdef KEYEXP_STORE_EN
    begin
      int          ridx [3] = '{43, 60, 4};
      logic [31:0] rexp [3] = '{32'hb6630ca6, 32'h0, 32'ha0fafe17};
      for (int k = 0; k < 3; k++) begin
        rd_idx_s[0] = 6'(ridx[k]);
        @(negedge clk);
        #1;
        checks++;
        if (rd_word_s[0] !== rexp[k]) begin
          errors++;
          $display("FAIL store_read rd_idx %0d: got %h, expected %h", ridx[k], rd_word_s[0], rexp[k]);
        end
      end
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      int cyc = 0, dcyc = 0;
      ready_s[1] = 1'b1;
      start_run(1, keys[1]);
      while (sb.size() > 0 && cyc < 200) begin
        cyc++;
        #1;
        if (wv[1]) begin
          e = sb.pop_front();
          checks++;
          if (wi[1] !== e.idx || wo[1] !== e.w) begin
            errors++;
            $display("FAIL b2b_stream run%0d: idx %0d word %h, expected idx %0d word %h",
                     r, wi[1], wo[1], e.idx, e.w);
          end
        end
        if (dn[1]) dcyc = cyc;
        @(negedge clk);
      end
      checks++;
      if (sb.size() != 0 || dcyc != 52) begin
        errors++;
        $display("FAIL b2b_done run%0d: left %0d done at %0d, expected 0 at 52", r, sb.size(), dcyc);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      start_s[s] = 1'b0;
      ready_s[s] = 1'b1;
`ifdef KEYEXP_STORE_EN
      rd_idx_s[s] = '0;
`endif
    end
    test_reset();
    test_streams();
    test_stall();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
